bisection_ctrl: RTL and testbench

BISECTION_CTRL -- requirements
Module: bisection_ctrl

---
 rtl/bisection_pkg.sv | 23 ++
 rtl/bisection_wb_regs.sv | 95 +++++++++
 rtl/bisection_ctrl.sv | 154 +++++++++++++++
 tb/tb_bisection_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bisection_pkg.sv
// Shared definitions for the bisection controller: register byte offsets,
// the controller FSM state type and the datapath widths.
package bisection_pkg;

  localparam int unsigned COEF_W  = 16;
  localparam int unsigned ALPHA_W = 20;
  localparam int unsigned ITER_W  = 16;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_COEF   = 8'h08;
  localparam logic [7:0] REG_ITER   = 8'h0C;
  localparam logic [7:0] REG_RESULT = 8'h10;
  localparam logic [7:0] REG_CYCLES = 8'h14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/bisection_wb_regs.sv
// Wishbone slave register file for the bisection controller.
// Ports: clk/reset (sync, active-low); wbs_* Wishbone slave bus;
// busy/done/early/result/cycles status from the FSM; coef/iter/irq_en
// configuration out; start/abort/done_clr single-cycle command strobes,
// decoded combinationally from the accepted write so they coincide with ack.
module bisection_wb_regs
  import bisection_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic               busy,
  input  logic               done,
  input  logic               early,
  input  logic [ALPHA_W-1:0] result,
  input  logic [ITER_W-1:0]  cycles,
  output logic [COEF_W-1:0]  coef,
  output logic [ITER_W-1:0]  iter,
  output logic               irq_en,
  output logic               start,
  output logic               abort,
  output logic               done_clr
);

  logic        hit;
  logic        req;
  logic        wr;
  logic [7:0]  offset;
  logic [31:0] rdata;
  logic        unused_bits;

  assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign offset = wbs_adr_i[7:0];
  // The !ack term makes back-to-back acks impossible.
  assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr     = req & wbs_we_i & hit;

  assign start    = wr & (offset == REG_CTRL)   & wbs_sel_i[0] & wbs_dat_i[0];
  assign abort    = wr & (offset == REG_CTRL)   & wbs_sel_i[0] & wbs_dat_i[1];
  assign done_clr = wr & (offset == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[1];

  assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (offset)
        REG_CTRL:   rdata[2]           = irq_en;
        REG_STATUS: rdata[2:0]         = {early, done, busy};
        REG_COEF:   rdata[COEF_W-1:0]  = coef;
        REG_ITER:   rdata[ITER_W-1:0]  = iter;
        REG_RESULT: rdata[ALPHA_W-1:0] = result;
        REG_CYCLES: rdata[ITER_W-1:0]  = cycles;
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      coef      <= '0;
      iter      <= '0;
      irq_en    <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req & ~wbs_we_i) ? rdata : '0;
      if (wr) begin
        case (offset)
          REG_CTRL: if (wbs_sel_i[0]) irq_en <= wbs_dat_i[2];
          REG_COEF: begin
            if (wbs_sel_i[0]) coef[7:0]  <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) coef[15:8] <= wbs_dat_i[15:8];
          end
          REG_ITER: begin
            if (wbs_sel_i[0]) iter[7:0]  <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) iter[15:8] <= wbs_dat_i[15:8];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/bisection_ctrl.sv
// Bisection core controller: Wishbone-programmed run sequencer.
// Ports: clk/reset (sync, active-low); wbs_* Wishbone slave bus;
// core_rst_o active-high core reset; coef_o coefficient shadow (z01 at
// [1:0] .. z14 at [15:14]); core_alpha_i root estimate from the core;
// irq_o level completion interrupt (done & irq_en).
module bisection_ctrl
  import bisection_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned STABLE    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               core_rst_o,
  output logic [COEF_W-1:0]  coef_o,
  input  logic [ALPHA_W-1:0] core_alpha_i,
  output logic               irq_o
);

  localparam int unsigned SW = $clog2(STABLE + 1);

  state_t              state;
  logic                load_second;
  logic [ITER_W-1:0]   cnt;
  logic [ITER_W-1:0]   cnt_next;
  logic [ITER_W-1:0]   iter;
  logic [ITER_W-1:0]   iter_eff;
  logic [ITER_W-1:0]   cycles;
  logic [SW-1:0]       same_cnt;
  logic [SW-1:0]       same_next;
  logic [ALPHA_W-1:0]  alpha_prev;
  logic [ALPHA_W-1:0]  result;
  logic [COEF_W-1:0]   coef;
  logic                rst_pulse;
  logic                done;
  logic                early;
  logic                early_hit;
  logic                busy;
  logic                irq_en;
  logic                start;
  logic                abort;
  logic                done_clr;
  logic                iter_hit;
  logic                stable_hit;

  bisection_wb_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .clk       (clk),
    .reset     (reset),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .busy      (busy),
    .done      (done),
    .early     (early),
    .result    (result),
    .cycles    (cycles),
    .coef      (coef),
    .iter      (iter),
    .irq_en    (irq_en),
    .start     (start),
    .abort     (abort),
    .done_clr  (done_clr)
  );

  assign busy       = (state != ST_IDLE);
  assign irq_o      = done & irq_en;
  // rst_pulse covers both the reset period and the one-cycle abort pulse.
  assign core_rst_o = (state == ST_LOAD) | rst_pulse;

  assign iter_eff = (iter == '0) ? ITER_W'(1) : iter;
  assign cnt_next = cnt + ITER_W'(1);
  assign iter_hit = (cnt_next == iter_eff);

  // Run length of identical alpha samples within the current run; the
  // first RUN cycle starts a fresh run of length one.
  always_comb begin
    same_next = SW'(1);
    if ((cnt != '0) && (core_alpha_i == alpha_prev)) same_next = same_cnt + SW'(1);
  end
  assign stable_hit = (same_next == SW'(STABLE));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      load_second <= 1'b0;
      cnt         <= '0;
      same_cnt    <= '0;
      alpha_prev  <= '0;
      result      <= '0;
      cycles      <= '0;
      done        <= 1'b0;
      early       <= 1'b0;
      early_hit   <= 1'b0;
      coef_o      <= '0;
      rst_pulse   <= 1'b1;
    end else begin
      rst_pulse <= abort;
      if (done_clr) done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state       <= ST_LOAD;
              load_second <= 1'b0;
              coef_o      <= coef;
              done        <= 1'b0;
              early       <= 1'b0;
              early_hit   <= 1'b0;
              cnt         <= '0;
              same_cnt    <= '0;
            end
          end
          ST_LOAD: begin
            load_second <= 1'b1;
            if (load_second) state <= ST_RUN;
          end
          ST_RUN: begin
            cnt        <= cnt_next;
            same_cnt   <= same_next;
            alpha_prev <= core_alpha_i;
            if (iter_hit || stable_hit) begin
              state     <= ST_CAPTURE;
              early_hit <= stable_hit;
            end
          end
          ST_CAPTURE: begin
            result <= core_alpha_i;
            cycles <= cnt;
            done   <= 1'b1;
            early  <= early_hit;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bisection_ctrl.sv
// Directed testbench for bisection_ctrl: drives Wishbone transactions and
// core_alpha_i patterns, compares against hand-computed values.
module tb_bisection_ctrl;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_STATUS = BASE + 32'h04;
  localparam logic [31:0] A_COEF   = BASE + 32'h08;
  localparam logic [31:0] A_ITER   = BASE + 32'h0C;
  localparam logic [31:0] A_RESULT = BASE + 32'h10;
  localparam logic [31:0] A_CYCLES = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        core_rst;
  logic [15:0] coef;
  logic [19:0] core_alpha;
  logic        irq;

  logic        alpha_toggle = 1'b0;
  logic [19:0] alpha_val = '0;
  int unsigned cycle_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  bisection_ctrl #(.BASE_ADDR(32'h3000_0000), .STABLE(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (wdat),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (rdat),
    .core_rst_o   (core_rst),
    .coef_o       (coef),
    .core_alpha_i (core_alpha),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Sole driver of core_alpha_i; updates mid-cycle on the falling edge.
  initial begin
    core_alpha = '0;
    forever begin
      @(negedge clk);
      if (alpha_toggle) core_alpha = (core_alpha == 20'h55555) ? 20'hAAAAA : 20'h55555;
      else core_alpha = alpha_val;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(tag, 32'(seen), 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    wait_ack("write_ack_timeout");
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    wait_ack("read_ack_timeout");
    d = rdat;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    check(tag, d, exp);
  endtask

  // Called right after the start write returns (inside the first LOAD
  // cycle). Edge i after the ack edge ends bus-cycle i; RUN cycle k spans
  // edges k+1..k+2, so the value set after edge i is RUN cycle i-1.
  task automatic wait_done(input int hold_k, input logic [19:0] hold_val, input int limit,
                           output int n, output int rst_hi);
    alpha_toggle = 1'b0;
    n = limit;
    rst_hi = core_rst ? 1 : 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (core_rst) rst_hi++;
      if (irq) begin
        n = i;
        break;
      end
      if ((i - 1) >= hold_k) alpha_val = hold_val;
      else alpha_val = (i % 2 == 1) ? 20'hAAAAA : 20'h55555;
    end
  endtask

  initial begin
    int n, rst_hi;
    int unsigned t0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_coef", 32'(coef), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_release_core_rst", 32'(core_rst), 32'd0);
    read_check("rst_status", A_STATUS, 32'd0);
    read_check("rst_ctrl", A_CTRL, 32'd0);
    read_check("rst_iter", A_ITER, 32'd0);
    read_check("rst_result", A_RESULT, 32'd0);
    read_check("rst_cycles", A_CYCLES, 32'd0);

    // Bus rules
    wb_write(A_COEF, 32'hFFFF_FFFF, 4'b0001);
    read_check("sel_lane_coef", A_COEF, 32'h0000_00FF);
    read_check("unmapped_off", BASE + 32'h20, 32'd0);
    read_check("other_base", 32'h4000_0008, 32'd0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_COEF; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("ack_pattern%0d", i), 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0;

    // Basic run: ITER=10, toggling alpha
    wb_write(A_COEF, 32'h0000_A5C3, 4'hF);
    wb_write(A_ITER, 32'd10, 4'hF);
    wb_write(A_CTRL, 32'h5, 4'h1);
    wait_done(1000, 20'h0, 40, n, rst_hi);
    check("basic_latency", 32'(n), 32'd13);
    check("basic_rst_cycles", 32'(rst_hi), 32'd2);
    check("basic_coef_o", 32'(coef), 32'h0000_A5C3);
    read_check("basic_result", A_RESULT, 32'h0005_5555);
    read_check("basic_cycles", A_CYCLES, 32'd10);
    read_check("basic_status", A_STATUS, 32'h2);

    // Interrupt gating and clear
    check("irq_with_done", 32'(irq), 32'd1);
    wb_write(A_CTRL, 32'h0, 4'h1);
    check("irq_masked", 32'(irq), 32'd0);
    read_check("done_kept", A_STATUS, 32'h2);
    wb_write(A_CTRL, 32'h4, 4'h1);
    check("irq_unmasked", 32'(irq), 32'd1);
    wb_write(A_STATUS, 32'h2, 4'h1);
    check("irq_cleared", 32'(irq), 32'd0);
    read_check("status_cleared", A_STATUS, 32'h0);

    // Early convergence: alpha held from RUN cycle 3
    wb_write(A_ITER, 32'd100, 4'hF);
    wb_write(A_CTRL, 32'h5, 4'h1);
    wait_done(3, 20'h12345, 40, n, rst_hi);
    check("early_latency", 32'(n), 32'd9);
    read_check("early_result", A_RESULT, 32'h0001_2345);
    read_check("early_cycles", A_CYCLES, 32'd6);
    read_check("early_status", A_STATUS, 32'h6);

    // ITER=0 behaves as one iteration
    wb_write(A_ITER, 32'd0, 4'hF);
    wb_write(A_CTRL, 32'h5, 4'h1);
    wait_done(1000, 20'h0, 40, n, rst_hi);
    check("iter0_latency", 32'(n), 32'd4);
    read_check("iter0_cycles", A_CYCLES, 32'd1);
    read_check("iter0_status", A_STATUS, 32'h2);

    // Abort mid-run with a prior RESULT of 0x77
    wb_write(A_ITER, 32'd1, 4'hF);
    wb_write(A_CTRL, 32'h5, 4'h1);
    wait_done(-10, 20'h00077, 40, n, rst_hi);
    read_check("pre_abort_result", A_RESULT, 32'h77);
    wb_write(A_ITER, 32'd100, 4'hF);
    alpha_toggle = 1'b1;
    wb_write(A_CTRL, 32'h5, 4'h1);
    repeat (6) @(posedge clk);
    wb_write(A_CTRL, 32'h6, 4'h1);
    check("abort_rst_pulse", 32'(core_rst), 32'd1);
    @(posedge clk); #1;
    check("abort_rst_end", 32'(core_rst), 32'd0);
    read_check("abort_status", A_STATUS, 32'h0);
    read_check("abort_result", A_RESULT, 32'h77);
    read_check("abort_cycles", A_CYCLES, 32'd1);

    // Busy protection
    wb_write(A_COEF, 32'h1234, 4'hF);
    wb_write(A_ITER, 32'd20, 4'hF);
    wb_write(A_CTRL, 32'h5, 4'h1);
    t0 = cycle_cnt;
    wb_write(A_COEF, 32'hFFFF, 4'hF);
    check("busy_coef_o", 32'(coef), 32'h1234);
    wb_write(A_CTRL, 32'h5, 4'h1);
    check("busy_start_ignored", 32'(core_rst), 32'd0);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (irq) break;
    end
    check("busy_latency", cycle_cnt - t0, 32'd23);
    read_check("busy_coef_reg", A_COEF, 32'hFFFF);
    wb_write(A_CTRL, 32'h7, 4'h1);
    check("start_abort_rst", 32'(core_rst), 32'd1);
    check("start_abort_coef_o", 32'(coef), 32'h1234);
    read_check("start_abort_status", A_STATUS, 32'h2);
    check("start_abort_irq", 32'(irq), 32'd1);

    // Reset mid-run abandons the run
    wb_write(A_ITER, 32'd50, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'h1);
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("midrun_reset_core_rst", 32'(core_rst), 32'd1);
    check("midrun_reset_coef", 32'(coef), 32'd0);
    @(negedge clk); reset = 1'b1;
    read_check("midrun_reset_status", A_STATUS, 32'h0);
    read_check("midrun_reset_cycles", A_CYCLES, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", checks);
    $fatal(1, "timeout");
  end

endmodule
